pipe_hazard_ctrl: RTL and testbench

Central sequencing controller for the 5-stage pipeline. It consumes the ID stage's Stall, Branch and Jump decisions and the instruction- and data-memory ready handshakes. It drives the PC and pipeline-register enables, flushes and bubbles. It also owns the post-reset pipeline scrub, the data-memory timeout and a stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : 5-stage pipeline sequencing (PC/IF-ID enables, flushes,
//                    bubbles), post-reset scrub, dmem timeout, stall counter
// Revision 1.0
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int INIT_CYCLES = 4,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Stall,
   input  logic             Branch,
   input  logic             Jump,
   input  logic             IMemReady,
   input  logic             DMemReq,
   input  logic             DMemReady,
   output logic             PCWrite,
   output logic             PCSelTarget,
   output logic             IFIDWrite,
   output logic             IFIDFlush,
   output logic             IDEXBubble,
   output logic             PipeFreeze,
   output logic             WBBubble,
   output logic             MemError,
   output logic [CNT_W-1:0] StallCycles
);

   localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [1:0] S_INIT  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DWAIT = 2'd2;
   localparam logic [1:0] S_ERROR = 2'd3;

   logic [1:0]        state_q,     state_d;
   logic [INIT_W-1:0] init_cnt_q,  init_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              mem_error_q, mem_error_d;

   logic dmem_wait;
   logic redirect;

   assign dmem_wait   = DMemReq & ~DMemReady;
   assign redirect    = Branch | Jump;
   assign MemError    = mem_error_q;
   assign StallCycles = stall_cnt_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= S_INIT;
         init_cnt_q  <= '0;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         mem_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         mem_error_q <= mem_error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      stall_cnt_d = stall_cnt_q;
      mem_error_d = mem_error_q;
      case (state_q)
         S_INIT: begin
            if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
               state_d    = S_RUN;
               init_cnt_d = '0;
            end else begin
               init_cnt_d = init_cnt_q + INIT_W'(1);
            end
         end
         S_RUN: begin
            if (dmem_wait) begin
               state_d    = S_DWAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         S_DWAIT: begin
            // A dropped request releases the wait just like a ready response.
            if (dmem_wait) begin
               if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                  state_d     = S_ERROR;
                  mem_error_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end else begin
               state_d    = S_RUN;
               wait_cnt_d = '0;
            end
         end
         default: begin
            state_d     = S_ERROR;
            mem_error_d = 1'b1;
         end
      endcase
      if ((state_q == S_RUN || state_q == S_DWAIT) && !PCWrite &&
          (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCSelTarget = 1'b0;
      IFIDWrite   = 1'b0;
      IFIDFlush   = 1'b0;
      IDEXBubble  = 1'b0;
      PipeFreeze  = 1'b0;
      WBBubble    = 1'b0;
      case (state_q)
         S_INIT: begin
            IFIDWrite  = 1'b1;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
            WBBubble   = 1'b1;
         end
         S_RUN, S_DWAIT: begin
            if (dmem_wait) begin
               PipeFreeze = 1'b1;
               WBBubble   = 1'b1;
            end else if (Stall) begin
               IDEXBubble = 1'b1;
            end else if (redirect) begin
               // Without the fetch ready the branch stays in ID and retries.
               if (IMemReady) begin
                  PCWrite     = 1'b1;
                  PCSelTarget = 1'b1;
                  IFIDWrite   = 1'b1;
                  IFIDFlush   = 1'b1;
               end else begin
                  IDEXBubble = 1'b1;
               end
            end else if (!IMemReady) begin
               IFIDWrite = 1'b1;
               IFIDFlush = 1'b1;
            end else begin
               PCWrite   = 1'b1;
               IFIDWrite = 1'b1;
            end
         end
         default: begin
            PipeFreeze = 1'b1;
            WBBubble   = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl : scoreboard bench for pipe_hazard_ctrl
// Revision 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int CW     = 4;
   localparam int MEM_TO = 16;

   // {PCWrite, PCSelTarget, IFIDWrite, IFIDFlush, IDEXBubble, PipeFreeze, WBBubble, MemError}
   localparam logic [7:0] E_INIT  = 8'b0011_1010;
   localparam logic [7:0] E_DWAIT = 8'b0000_0110;
   localparam logic [7:0] E_HOLD  = 8'b0000_1000;
   localparam logic [7:0] E_REDIR = 8'b1111_0000;
   localparam logic [7:0] E_FWAIT = 8'b0011_0000;
   localparam logic [7:0] E_NORM  = 8'b1010_0000;
   localparam logic [7:0] E_ERR   = 8'b0000_0111;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b1;
   logic          Stall = 1'b0, Branch = 1'b0, Jump = 1'b0;
   logic          IMemReady = 1'b1, DMemReq = 1'b0, DMemReady = 1'b0;
   logic          PCWrite, PCSelTarget, IFIDWrite, IFIDFlush;
   logic          IDEXBubble, PipeFreeze, WBBubble, MemError;
   logic [CW-1:0] StallCycles;
   logic [7:0]    obs;

   typedef struct packed {
      logic [7:0]    o;
      logic [CW-1:0] sc;
   } exp_t;

   exp_t          sb_q[$];
   logic [CW-1:0] exp_sc = '0;
   int            n_tests = 0;
   int            n_fail  = 0;
   int            n_item  = 0;

   assign obs = {PCWrite, PCSelTarget, IFIDWrite, IFIDFlush,
                 IDEXBubble, PipeFreeze, WBBubble, MemError};

   pipe_hazard_ctrl #(
      .INIT_CYCLES (4),
      .MEM_TIMEOUT (MEM_TO),
      .CNT_W       (CW)
   ) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .Stall       (Stall),
      .Branch      (Branch),
      .Jump        (Jump),
      .IMemReady   (IMemReady),
      .DMemReq     (DMemReq),
      .DMemReady   (DMemReady),
      .PCWrite     (PCWrite),
      .PCSelTarget (PCSelTarget),
      .IFIDWrite   (IFIDWrite),
      .IFIDFlush   (IFIDFlush),
      .IDEXBubble  (IDEXBubble),
      .PipeFreeze  (PipeFreeze),
      .WBBubble    (WBBubble),
      .MemError    (MemError),
      .StallCycles (StallCycles)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One pipeline cycle: drive inputs just after the edge and queue what the
   // outputs and counter must show during that cycle.
   task automatic step(input logic st, input logic br, input logic jp, input logic imr,
                       input logic dq, input logic dr, input logic [7:0] e, input bit counted);
      exp_t it;
      @(posedge Clk);
      #1;
      Stall = st; Branch = br; Jump = jp;
      IMemReady = imr; DMemReq = dq; DMemReady = dr;
      it.o  = e;
      it.sc = exp_sc;
      sb_q.push_back(it);
      if (counted && !e[7] && exp_sc != '1) exp_sc = exp_sc + 1'b1;
   endtask

   task automatic release_reset();
      exp_t it;
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      Stall = 1'b0; Branch = 1'b0; Jump = 1'b0;
      IMemReady = 1'b1; DMemReq = 1'b0; DMemReady = 1'b0;
      exp_sc = '0;
      it.o   = E_INIT;
      it.sc  = '0;
      sb_q.push_back(it);
   endtask

   always @(negedge Clk) begin : mon
      exp_t it;
      if (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         chk($sformatf("outs[%0d]", n_item), 32'(obs), 32'(it.o));
         chk($sformatf("stall_cycles[%0d]", n_item), 32'(StallCycles), 32'(it.sc));
         n_item++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1 Reset_n = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("reset_outs", 32'(obs), 32'(E_INIT));
      chk("reset_stall_cycles", 32'(StallCycles), 32'd0);

      release_reset();
      repeat (3) step(0, 0, 0, 1, 0, 0, E_INIT, 0);
      repeat (3) step(0, 0, 0, 1, 0, 0, E_NORM, 1);

      // Load-use masks a simultaneous branch, which then redirects next cycle.
      step(1, 1, 0, 1, 0, 0, E_HOLD,  1);
      step(0, 1, 0, 1, 0, 0, E_REDIR, 1);
      step(0, 0, 0, 1, 0, 0, E_NORM,  1);

      repeat (2) step(0, 0, 1, 0, 0, 0, E_HOLD, 1);
      step(0, 0, 1, 1, 0, 0, E_REDIR, 1);
      step(0, 0, 0, 1, 0, 0, E_NORM,  1);

      repeat (3) step(1, 0, 0, 1, 1, 0, E_DWAIT, 1);
      step(1, 0, 0, 1, 1, 1, E_HOLD, 1);
      step(0, 0, 0, 1, 0, 0, E_NORM, 1);

      repeat (20) step(1, 0, 0, 1, 0, 0, E_HOLD, 1);
      step(0, 0, 0, 1, 0, 0, E_NORM, 1);

      // RUN entry plus MEM_TO further DWAIT cycles before the timeout edge.
      repeat (MEM_TO + 1) step(0, 0, 0, 1, 1, 0, E_DWAIT, 1);
      repeat (3) step(0, 0, 0, 1, 1, 0, E_ERR, 0);
      step(0, 0, 0, 1, 0, 0, E_ERR, 0);

      @(negedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      chk("rst_pulse_outs", 32'(obs), 32'(E_INIT));
      chk("rst_pulse_stall_cycles", 32'(StallCycles), 32'd0);

      release_reset();
      repeat (3) step(1, 1, 1, 0, 1, 0, E_INIT, 0);
      step(0, 0, 0, 0, 0, 0, E_FWAIT, 1);
      step(1, 1, 0, 1, 1, 0, E_DWAIT, 1);
      step(0, 1, 0, 1, 0, 0, E_REDIR, 1);
      step(0, 0, 0, 1, 0, 0, E_NORM,  1);
      step(0, 0, 0, 1, 0, 0, E_NORM,  1);

      @(negedge Clk);
      #1;
      chk("queue_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
